// File: rtl/m_proc_mc.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXEC/MEM/WB over one shared ALU,
// with local instruction/data memories, a register file and a debug read port.
module m_proc_mc #(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int unsigned IMEM_AW  = 6,
   parameter int unsigned DMEM_AW  = 6,
   parameter int unsigned HALT_REG = 30
) (
   input  logic               w_clk,
   input  logic               w_rst_n,
   input  logic               w_imem_we,
   input  logic [IMEM_AW-1:0] w_imem_wa,
   input  logic [31:0]        w_imem_wd,
   input  logic [4:0]         w_dbg_ra,
   output logic [31:0]        w_dbg_rd,
   output logic [31:0]        w_pc,
   output logic               w_retire,
   output logic               w_halt,
   output logic               w_err
);

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [4:0] HALT_RD = 5'(HALT_REG);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] imm_q, imm_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] mdr_q, mdr_d;
   logic        err_q, err_d;

   logic [31:0] imem_q [2**IMEM_AW];
   logic [31:0] dmem_q [2**DMEM_AW];
   logic [31:0] regs_q [32];

   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic        legal;
   logic [31:0] pc_inc;
   logic [31:0] alu_a, alu_b, alu_y;
   logic        alu_sub;
   logic        br_taken;
   logic        rf_we;
   logic [31:0] rf_wd;
   logic        dmem_we;
   logic        retire;

   assign opcode = ir_q[6:0];
   assign rd     = ir_q[11:7];
   assign funct3 = ir_q[14:12];
   assign rs1    = ir_q[19:15];
   assign rs2    = ir_q[24:20];
   assign pc_inc = pc_q + 32'd4;

   always_comb begin
      legal = 1'b0;
      case (opcode)
         OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_LUI, OP_JAL: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   // Operand steering for the single ALU; jal uses it twice (link in EXEC, target in WB).
   always_comb begin
      alu_a   = a_q;
      alu_b   = b_q;
      alu_sub = 1'b0;
      case (opcode)
         OP_R:               alu_sub = ir_q[30];
         OP_I, OP_LW, OP_SW: alu_b   = imm_q;
         OP_LUI: begin
            alu_a = '0;
            alu_b = imm_q;
         end
         OP_JAL: begin
            alu_a = pc_q;
            alu_b = (state_q == S_WB) ? imm_q : 32'd4;
         end
         OP_BR: begin
            alu_a = pc_q;
            alu_b = imm_q;
         end
         default: ;
      endcase
      alu_y = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
   end

   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         3'b000:  br_taken = (a_q == b_q);
         3'b001:  br_taken = (a_q != b_q);
         default: br_taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      imm_d   = imm_q;
      alu_d   = alu_q;
      mdr_d   = mdr_q;
      err_d   = err_q;
      rf_we   = 1'b0;
      rf_wd   = alu_q;
      dmem_we = 1'b0;
      retire  = 1'b0;

      case (state_q)
         S_FETCH: begin
            ir_d    = imem_q[pc_q[IMEM_AW+1:2]];
            state_d = S_DECODE;
         end
         S_DECODE: begin
            a_d = regs_q[rs1];
            b_d = regs_q[rs2];
            case (opcode)
               OP_SW:   imm_d = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
               OP_BR:   imm_d = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25],
                                 ir_q[11:8], 1'b0};
               OP_LUI:  imm_d = {ir_q[31:12], 12'h000};
               OP_JAL:  imm_d = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20],
                                 ir_q[30:21], 1'b0};
               default: imm_d = {{20{ir_q[31]}}, ir_q[31:20]};
            endcase
            if (legal) begin
               state_d = S_EXEC;
            end else begin
               err_d   = 1'b1;
               state_d = S_HALT;
            end
         end
         S_EXEC: begin
            alu_d = alu_y;
            if (opcode == OP_BR) begin
               pc_d    = br_taken ? alu_y : pc_inc;
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (opcode == OP_LW || opcode == OP_SW) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (opcode == OP_SW) begin
               dmem_we = 1'b1;
               pc_d    = pc_inc;
               retire  = 1'b1;
               state_d = S_FETCH;
            end else begin
               mdr_d   = dmem_q[alu_q[DMEM_AW+1:2]];
               state_d = S_WB;
            end
         end
         S_WB: begin
            rf_we   = (rd != 5'd0);
            rf_wd   = (opcode == OP_LW) ? mdr_q : alu_q;
            pc_d    = (opcode == OP_JAL) ? alu_y : pc_inc;
            retire  = 1'b1;
            state_d = (rd == HALT_RD && rd != 5'd0) ? S_HALT : S_FETCH;
         end
         default: state_d = S_HALT;
      endcase
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         alu_q   <= '0;
         mdr_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         imm_q   <= imm_d;
         alu_q   <= alu_d;
         mdr_q   <= mdr_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (rf_we) begin
         regs_q[rd] <= rf_wd;
      end
   end

   // Memories are not reset so a program loaded under reset survives release.
   always_ff @(posedge w_clk) begin
      if (w_imem_we) imem_q[w_imem_wa] <= w_imem_wd;
   end

   always_ff @(posedge w_clk) begin
      if (dmem_we) dmem_q[alu_q[DMEM_AW+1:2]] <= b_q;
   end

   assign w_dbg_rd = (w_dbg_ra == 5'd0) ? '0 : regs_q[w_dbg_ra];
   assign w_pc     = pc_q;
   assign w_retire = retire;
   assign w_halt   = (state_q == S_HALT);
   assign w_err    = err_q;

endmodule
